// File: rtl/fb_ram_if.sv
// Frame-buffer RAM bus: pixel writer, pixel reader and clear control/status.
interface fb_ram_if #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 12,
  parameter int NUM_LANES = 3
);
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic [NUM_LANES-1:0] wr_be;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [DATA_W-1:0]    rd_data;
  logic                 rd_valid;
  logic                 clear_start;
  logic                 clear_busy;
  logic                 clear_done;
  logic                 addr_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clear_start,
    input  rd_data, rd_valid, clear_busy, clear_done, addr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clear_start,
    output rd_data, rd_valid, clear_busy, clear_done, addr_err
  );
endinterface

// File: rtl/fb_ram_ctl.sv
// Single-clock frame-buffer RAM with per-lane write enables, 1- or 2-cycle
// read latency, selectable read-during-write behaviour, address range
// checking and a sweep engine that fills the whole buffer with CLEAR_VAL.
module fb_ram_ctl #(
  parameter int               DATA_W    = 12,
  parameter int               LANE_W    = 4,
  parameter int               NUM_LANES = 3,
  parameter int               DEPTH     = 307200,
  parameter int               ADDR_W    = 19,
  parameter int               READ_LAT  = 1,
  parameter int               RDW_MODE  = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic     clk,
  input  logic     rst,
  fb_ram_if.slave  bus
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              clear_busy_r;
  logic              clear_done_r;
  logic              addr_err_r;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              wr_acc, rd_acc, wr_in, rd_in, wr_ok;
  logic [IDX_W-1:0]  wr_idx, rd_idx, cnt_idx;
  logic [DATA_W-1:0] rd_word_p0;
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;

  // Replace the enabled lanes of a stored word with the incoming write data.
  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0]    old_w,
    input logic [DATA_W-1:0]    new_w,
    input logic [NUM_LANES-1:0] be
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (be[i]) r[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
    end
    return r;
  endfunction

  // Port requests only count while the clear engine is not sweeping.
  assign wr_acc  = (state == IDLE) && bus.wr_en;
  assign rd_acc  = (state == IDLE) && bus.rd_en;
  assign wr_in   = {1'b0, bus.wr_addr} < DEPTH_X;
  assign rd_in   = {1'b0, bus.rd_addr} < DEPTH_X;
  assign wr_ok   = wr_acc && wr_in;
  assign wr_idx  = bus.wr_addr[IDX_W-1:0];
  assign rd_idx  = bus.rd_addr[IDX_W-1:0];
  assign cnt_idx = cnt[IDX_W-1:0];

  // Clear FSM: IDLE services the ports, CLEAR sweeps one word per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      clear_busy_r <= 1'b0;
      clear_done_r <= 1'b0;
    end else begin
      clear_done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear_start) begin
            state        <= CLEAR;
            cnt          <= '0;
            clear_busy_r <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            state        <= IDLE;
            clear_busy_r <= 1'b0;
            clear_done_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage: the sweep writes full words, the port writes only enabled lanes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cnt_idx] <= CLEAR_VAL;
      end else if (wr_ok) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (bus.wr_be[i]) mem[wr_idx][i*LANE_W +: LANE_W] <= bus.wr_data[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Read word seen this cycle; out-of-range reads return zero.
  always_comb begin
    rd_word_p0 = '0;
    if (rd_in) begin
      rd_word_p0 = mem[rd_idx];
      if (RDW_MODE == 1 && wr_ok && (bus.wr_addr == bus.rd_addr)) begin
        rd_word_p0 = lane_merge(mem[rd_idx], bus.wr_data, bus.wr_be);
      end
    end
  end

  // ---- stage p1: first read register, data held while no read is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) rd_data_p1 <= rd_word_p0;
    end
  end

  // One-cycle pulse for any accepted access that falls outside the buffer.
  always_ff @(posedge clk) begin
    if (rst) addr_err_r <= 1'b0;
    else     addr_err_r <= (wr_acc && !wr_in) || (rd_acc && !rd_in);
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] rd_data_p2;
      logic              vld_p2;

      // ---- stage p2: optional output register for the two-cycle latency
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p2     <= 1'b0;
          rd_data_p2 <= '0;
        end else begin
          vld_p2 <= vld_p1;
          if (vld_p1) rd_data_p2 <= rd_data_p1;
        end
      end

      assign bus.rd_data  = rd_data_p2;
      assign bus.rd_valid = vld_p2;
    end else begin : g_lat1
      assign bus.rd_data  = rd_data_p1;
      assign bus.rd_valid = vld_p1;
    end
  endgenerate

  assign bus.clear_busy = clear_busy_r;
  assign bus.clear_done = clear_done_r;
  assign bus.addr_err   = addr_err_r;

endmodule

// File: tb/tb_fb_ram_ctl.sv
// Directed bench: two instances share one stimulus stream, A with one-cycle
// read latency and read-first collisions, B with two-cycle latency and
// write-first collisions. Both use a 16-word buffer and a 12'h0F0 fill colour.
module tb_fb_ram_ctl;

  localparam int AW = 5;
  localparam int DW = 12;
  localparam int NL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  int busy_cnt, done_cnt, done_at, stray, errs;

  fb_ram_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_LANES(NL)) ia ();
  fb_ram_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_LANES(NL)) ib ();

  assign ib.wr_en       = ia.wr_en;
  assign ib.wr_addr     = ia.wr_addr;
  assign ib.wr_data     = ia.wr_data;
  assign ib.wr_be       = ia.wr_be;
  assign ib.rd_en       = ia.rd_en;
  assign ib.rd_addr     = ia.rd_addr;
  assign ib.clear_start = ia.clear_start;

  fb_ram_ctl #(.DATA_W(DW), .LANE_W(4), .NUM_LANES(NL), .DEPTH(16), .ADDR_W(AW),
               .READ_LAT(1), .RDW_MODE(0), .CLEAR_VAL(12'h0F0))
    dut_a (.clk(clk), .rst(rst), .bus(ia));

  fb_ram_ctl #(.DATA_W(DW), .LANE_W(4), .NUM_LANES(NL), .DEPTH(16), .ADDR_W(AW),
               .READ_LAT(2), .RDW_MODE(1), .CLEAR_VAL(12'h0F0))
    dut_b (.clk(clk), .rst(rst), .bus(ib));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] be);
    ia.wr_en = 1'b1; ia.wr_addr = a; ia.wr_data = d; ia.wr_be = be;
    tick();
    ia.wr_en = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [AW-1:0] a,
                          input logic [DW-1:0] exp_a, input logic [DW-1:0] exp_b);
    ia.rd_en = 1'b1; ia.rd_addr = a;
    tick();
    ia.rd_en = 1'b0;
    chk({tag, "_a_vld"}, 32'(ia.rd_valid), 32'd1);
    chk({tag, "_a_dat"}, 32'(ia.rd_data), 32'(exp_a));
    chk({tag, "_b_early"}, 32'(ib.rd_valid), 32'd0);
    tick();
    chk({tag, "_b_vld"}, 32'(ib.rd_valid), 32'd1);
    chk({tag, "_b_dat"}, 32'(ib.rd_data), 32'(exp_b));
    chk({tag, "_a_drop"}, 32'(ia.rd_valid), 32'd0);
  endtask

  initial begin
    ia.wr_en = 1'b0; ia.wr_addr = '0; ia.wr_data = '0; ia.wr_be = '0;
    ia.rd_en = 1'b0; ia.rd_addr = '0; ia.clear_start = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_a_vld",  32'(ia.rd_valid),   32'd0);
    chk("rst_a_dat",  32'(ia.rd_data),    32'd0);
    chk("rst_b_vld",  32'(ib.rd_valid),   32'd0);
    chk("rst_b_dat",  32'(ib.rd_data),    32'd0);
    chk("rst_busy",   32'(ia.clear_busy), 32'd0);
    chk("rst_done",   32'(ia.clear_done), 32'd0);
    chk("rst_err",    32'(ia.addr_err),   32'd0);
    rst = 1'b0;

    // basic write/read
    wr(5'd5, 12'hABC, 3'b111);
    rd_check("t1", 5'd5, 12'hABC, 12'hABC);
    chk("t1_hold", 32'(ia.rd_data), 32'hABC);

    // lane enables
    wr(5'd7, 12'h123, 3'b111);
    wr(5'd7, 12'hFFF, 3'b010);
    rd_check("t2", 5'd7, 12'h1F3, 12'h1F3);

    // read-during-write on the same address
    wr(5'd9, 12'h111, 3'b111);
    ia.wr_en = 1'b1; ia.wr_addr = 5'd9; ia.wr_data = 12'h222; ia.wr_be = 3'b111;
    ia.rd_en = 1'b1; ia.rd_addr = 5'd9;
    tick();
    ia.wr_en = 1'b0; ia.rd_en = 1'b0;
    chk("t3_a_old", 32'(ia.rd_data), 32'h111);
    tick();
    chk("t3_b_new", 32'(ib.rd_data), 32'h222);
    rd_check("t3_after", 5'd9, 12'h222, 12'h222);

    // back-to-back reads
    ia.rd_en = 1'b1; ia.rd_addr = 5'd5;
    tick();
    chk("b2b_a0", 32'(ia.rd_data), 32'hABC);
    ia.rd_addr = 5'd7;
    tick();
    ia.rd_en = 1'b0;
    chk("b2b_a1",   32'(ia.rd_data),  32'h1F3);
    chk("b2b_a1v",  32'(ia.rd_valid), 32'd1);
    chk("b2b_b0",   32'(ib.rd_data),  32'hABC);
    tick();
    chk("b2b_b1",   32'(ib.rd_data),  32'h1F3);
    chk("b2b_b1v",  32'(ib.rd_valid), 32'd1);

    // out-of-range write and read
    wr(5'd0, 12'h5A5, 3'b111);
    ia.wr_en = 1'b1; ia.wr_addr = 5'd16; ia.wr_data = 12'hEEE; ia.wr_be = 3'b111;
    tick();
    ia.wr_en = 1'b0;
    chk("t4_werr", 32'(ia.addr_err), 32'd1);
    tick();
    chk("t4_werr_pulse", 32'(ia.addr_err), 32'd0);
    ia.rd_en = 1'b1; ia.rd_addr = 5'd19;
    tick();
    ia.rd_en = 1'b0;
    chk("t4_rerr",  32'(ia.addr_err), 32'd1);
    chk("t4_rvld",  32'(ia.rd_valid), 32'd1);
    chk("t4_rdat",  32'(ia.rd_data),  32'd0);
    tick();
    chk("t4_rerr_pulse", 32'(ia.addr_err), 32'd0);
    chk("t4_b_vld", 32'(ib.rd_valid), 32'd1);
    chk("t4_b_dat", 32'(ib.rd_data),  32'd0);
    rd_check("t4_w0", 5'd0, 12'h5A5, 12'h5A5);

    // clear sweep, with a same-cycle write and read in the start cycle
    ia.clear_start = 1'b1;
    ia.wr_en = 1'b1; ia.wr_addr = 5'd3; ia.wr_data = 12'h777; ia.wr_be = 3'b111;
    ia.rd_en = 1'b1; ia.rd_addr = 5'd5;
    tick();
    ia.clear_start = 1'b0; ia.wr_en = 1'b0; ia.rd_addr = 5'd19;
    chk("t5_busy",  32'(ia.clear_busy), 32'd1);
    chk("t5_a_vld", 32'(ia.rd_valid),   32'd1);
    chk("t5_a_dat", 32'(ia.rd_data),    32'hABC);
    busy_cnt = 1; done_cnt = 0; done_at = 0; stray = 0; errs = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 1)  begin ia.wr_en = 1'b1; ia.wr_addr = 5'd2; ia.wr_data = 12'h333; end
      if (i == 8)  ia.clear_start = 1'b1;
      if (i == 9)  ia.clear_start = 1'b0;
      if (i == 17) begin ia.rd_en = 1'b0; ia.wr_en = 1'b0; end
      tick();
      if (i == 1) chk("t5_b_pipe", 32'(ib.rd_data), 32'hABC);
      if (ia.clear_busy) busy_cnt++;
      if (ia.clear_done) begin done_cnt++; done_at = i; end
      if (ia.rd_valid) stray++;
      if (i >= 2 && ib.rd_valid) stray++;
      if (ia.addr_err) errs++;
    end
    chk("t5_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("t5_done_count",  32'(done_cnt), 32'd1);
    chk("t5_done_at",     32'(done_at),  32'd16);
    chk("t5_stray_vld",   32'(stray),    32'd0);
    chk("t5_stray_err",   32'(errs),     32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_check($sformatf("t5_w%0d", i), AW'(i), 12'h0F0, 12'h0F0);
    end

    // clear aborted by reset
    for (int i = 0; i < 16; i++) wr(AW'(i), 12'h500 + DW'(i), 3'b111);
    ia.clear_start = 1'b1;
    tick();
    ia.clear_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    chk("t6_busy", 32'(ia.clear_busy), 32'd0);
    chk("t6_done", 32'(ia.clear_done), 32'd0);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ia.clear_done || ib.clear_done) done_cnt++;
    end
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i < 5) rd_check($sformatf("t6_w%0d", i), AW'(i), 12'h0F0, 12'h0F0);
      else       rd_check($sformatf("t6_w%0d", i), AW'(i), 12'h500 + DW'(i), 12'h500 + DW'(i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
